mem_stage_sync: RTL and testbench

Pipeline-advance controller for the memory stage of the RISC-V core. It generalises the fixed two-response (instruction + data) handshake to NUM_PORTS memory ports. Responses arriving in any order and in different cycles are captured stickily, and a one-cycle `advance` pulse is issued once every port required for the current stage occupancy has responded. It sits between the cache/memory response signals and the pipeline register enables, and adds flush, stall-cycle counting and timeout reporting.

---
 rtl/mem_stage_sync_pkg.sv | 13 +
 rtl/mem_stage_sync_resp_capture.sv | 23 ++
 rtl/mem_stage_sync.sv | 106 ++++++++++
 tb/tb_mem_stage_sync.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sync_pkg.sv
// Shared types and default sizing for the memory-stage advance controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ADV  = 2'd2
  } mem_stage_state_e;

  localparam int DEFAULT_NUM_PORTS = 2;
  localparam int DEFAULT_CNT_W     = 8;

endpackage

// File: rtl/mem_stage_sync_resp_capture.sv
// Sticky per-port response flags: set bits accumulate until cleared by the stage controller.
module resp_capture #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clear,
  input  logic [WIDTH-1:0] set,
  output logic [WIDTH-1:0] done
);

  // A clear and a set in the same cycle reload the flags with the new set bits only,
  // which lets a fresh occupancy capture responses that arrive with its start.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      done <= '0;
    end else begin
      done <= (clear ? '0 : done) | set;
    end
  end

endmodule

// File: rtl/mem_stage_sync.sv
// Memory-stage advance controller: waits for every required port to respond, then pulses advance.
module mem_stage_sync
  import mem_stage_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_PORTS-1:0] need,
  input  logic [NUM_PORTS-1:0] resp,
  input  logic                 flush,
  output logic                 advance,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] pending,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  // A threshold the counter can never reach behaves as disabled rather than aliasing.
  localparam bit TIMEOUT_EN = (TIMEOUT > 0) && (longint'(TIMEOUT) <= longint'(CNT_MAX));

  mem_stage_state_e     state;
  logic [NUM_PORTS-1:0] need_r;
  logic [NUM_PORTS-1:0] done_r;
  logic [NUM_PORTS-1:0] set_vec;
  logic [NUM_PORTS-1:0] eff_need;
  logic [NUM_PORTS-1:0] captured;
  logic                 accept_start;
  logic                 complete;
  logic                 cap_clear;

  // Start is honoured from IDLE and ADV only; completion looks at this cycle's responses too.
  always_comb begin
    accept_start = start && (state != WAIT);
    set_vec      = '0;
    eff_need     = need_r;
    captured     = done_r;
    if (accept_start) begin
      set_vec  = resp & need;
      eff_need = need;
      captured = resp & need;
    end else if (state == WAIT) begin
      set_vec  = resp & need_r;
      captured = done_r | (resp & need_r);
    end
    complete  = (captured == eff_need);
    cap_clear = accept_start || (state != WAIT);
  end

  resp_capture #(
    .WIDTH(NUM_PORTS)
  ) u_capture (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .clear(cap_clear),
    .set  (set_vec),
    .done (done_r)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= IDLE;
      need_r       <= '0;
      stall_cycles <= '0;
      timeout      <= 1'b0;
      advance      <= 1'b0;
    end else begin
      advance <= 1'b0;
      case (state)
        WAIT: begin
          if (stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
          if (TIMEOUT_EN && (stall_cycles == TIMEOUT_VAL)) timeout <= 1'b1;
          if (complete) begin
            state   <= ADV;
            advance <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            need_r       <= need;
            stall_cycles <= '0;
            timeout      <= 1'b0;
            if (complete) begin
              state   <= ADV;
              advance <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (state == WAIT);
  assign pending = busy ? (need_r & ~done_r) : '0;

endmodule

// File: tb/tb_mem_stage_sync.sv
// Self-checking bench for mem_stage_sync: directed table, corner sequences and random traffic vs a model.
module tb_mem_stage_sync;

  logic       clk = 1'b0;
  logic       rst, start, flush;
  logic [1:0] need, resp;

  logic       a_advance, a_busy, a_timeout;
  logic [1:0] a_pending;
  logic [2:0] a_stall;
  logic       b_advance, b_busy, b_timeout;
  logic [1:0] b_pending;
  logic [7:0] b_stall;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural view of an occupancy: active/required/received sets and per-instance counters.
  logic       m_active, m_adv, m_to_a;
  logic [1:0] m_need, m_got;
  int         m_stall_a, m_stall_b;

  always #5 clk = ~clk;

  mem_stage_sync #(.NUM_PORTS(2), .CNT_W(3), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .need(need), .resp(resp), .flush(flush),
    .advance(a_advance), .busy(a_busy), .pending(a_pending),
    .stall_cycles(a_stall), .timeout(a_timeout)
  );

  mem_stage_sync #(.NUM_PORTS(2), .CNT_W(8), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .need(need), .resp(resp), .flush(flush),
    .advance(b_advance), .busy(b_busy), .pending(b_pending),
    .stall_cycles(b_stall), .timeout(b_timeout)
  );

  typedef struct {
    logic       start;
    logic [1:0] need;
    logic [1:0] resp;
    logic       exp_adv;
    logic       exp_busy;
    logic [1:0] exp_pend;
    int         exp_stall;
    logic       exp_to;
  } vec_t;

  vec_t vecs[19];

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst || flush) begin
      m_active = 1'b0; m_adv = 1'b0; m_to_a = 1'b0;
      m_need = '0; m_got = '0; m_stall_a = 0; m_stall_b = 0;
    end else if (start && !m_active) begin
      m_need = need;
      m_got = resp & need;
      m_stall_a = 0; m_stall_b = 0; m_to_a = 1'b0;
      m_adv = (m_got == m_need);
      m_active = !m_adv;
    end else if (m_active) begin
      if (m_stall_a == 4) m_to_a = 1'b1;
      m_stall_a = (m_stall_a < 7) ? m_stall_a + 1 : 7;
      m_stall_b = (m_stall_b < 255) ? m_stall_b + 1 : 255;
      m_got = m_got | (resp & m_need);
      m_adv = (m_got == m_need);
      m_active = !m_adv;
    end else begin
      m_adv = 1'b0;
    end
  endtask

  task automatic check_model();
    logic [1:0] exp_pend;
    exp_pend = m_active ? (m_need & ~m_got) : 2'b00;
    check_output("a.advance", int'(a_advance), int'(m_adv));
    check_output("a.busy", int'(a_busy), int'(m_active));
    check_output("a.pending", int'(a_pending), int'(exp_pend));
    check_output("a.stall", int'(a_stall), m_stall_a);
    check_output("a.timeout", int'(a_timeout), int'(m_to_a));
    check_output("b.advance", int'(b_advance), int'(m_adv));
    check_output("b.busy", int'(b_busy), int'(m_active));
    check_output("b.pending", int'(b_pending), int'(exp_pend));
    check_output("b.stall", int'(b_stall), m_stall_b);
    check_output("b.timeout", int'(b_timeout), 0);
  endtask

  task automatic apply_stimulus(input logic s, input logic f, input logic r,
                                input logic [1:0] n, input logic [1:0] rs);
    start = s; flush = f; rst = r; need = n; resp = rs;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; need = '0; resp = '0;
    m_active = 1'b0; m_adv = 1'b0; m_to_a = 1'b0;
    m_need = '0; m_got = '0; m_stall_a = 0; m_stall_b = 0;

    vecs[0]  = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b11, 0, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 1, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10, 2, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 4, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 5, 1'b1};
    vecs[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 5, 1'b1};
    vecs[7]  = '{1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 0, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 2'b01, 0, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 2'b01, 1, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2, 1'b0};
    vecs[13] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 0, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 0, 1'b0};
    vecs[15] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 0, 1'b0};
    vecs[16] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 2'b01, 1, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2, 1'b0};

    apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
    check_output("reset.advance", int'(a_advance), 0);
    check_output("reset.busy", int'(a_busy), 0);
    check_output("reset.pending", int'(a_pending), 0);
    check_output("reset.stall", int'(a_stall), 0);
    check_output("reset.timeout", int'(a_timeout), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].start, 1'b0, 1'b0, vecs[i].need, vecs[i].resp);
      check_output($sformatf("vec%0d.advance", i), int'(a_advance), int'(vecs[i].exp_adv));
      check_output($sformatf("vec%0d.busy", i), int'(a_busy), int'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d.pending", i), int'(a_pending), int'(vecs[i].exp_pend));
      check_output($sformatf("vec%0d.stall_a", i), int'(a_stall), vecs[i].exp_stall);
      check_output($sformatf("vec%0d.stall_b", i), int'(b_stall), vecs[i].exp_stall);
      check_output($sformatf("vec%0d.timeout", i), int'(a_timeout), int'(vecs[i].exp_to));
    end

    // Back-to-back occupancies with coincident responses
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
      check_output("b2b.advance", int'(a_advance), 1);
      check_output("b2b.busy", int'(a_busy), 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_output("b2b.end_advance", int'(a_advance), 0);

    // Timeout, saturation and flush recovery
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      if (k == 4) begin
        check_output("to.stall_at4", int'(a_stall), 4);
        check_output("to.not_yet", int'(a_timeout), 0);
      end
      if (k == 5) check_output("to.rise", int'(a_timeout), 1);
      if (k == 9) begin
        check_output("to.sat_a", int'(a_stall), 7);
        check_output("to.stall_b", int'(b_stall), 9);
        check_output("to.disabled_b", int'(b_timeout), 0);
      end
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b11);
    check_output("flush.stall", int'(a_stall), 0);
    check_output("flush.timeout", int'(a_timeout), 0);
    check_output("flush.advance", int'(a_advance), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_output("flush.no_late_adv", int'(a_advance), 0);

    // Flush against a completing response, and against a start
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b01);
    check_output("flushresp.advance", int'(a_advance), 0);
    check_output("flushresp.busy", int'(a_busy), 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'b00, 2'b11);
    check_output("flushstart.advance", int'(a_advance), 0);

    // Reset in the middle of a wait
    apply_stimulus(1'b1, 1'b0, 1'b0, 2'b11, 2'b01);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b10);
    check_output("rstwait.busy", int'(a_busy), 0);
    check_output("rstwait.pending", int'(a_pending), 0);
    check_output("rstwait.advance", int'(a_advance), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
